// File: rtl/pipe_pkg.sv
// Shared types and constants for the FD/EX pipeline sequencing controller.
package pipe_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } pipe_state_t;

   typedef struct packed {
      logic pc_en;
      logic pc_redirect;
      logic fd_en;
      logic fd_flush;
      logic ex_en;
      logic ex_bubble;
   } pipe_ctl_t;

   // Canonical control bundles, one per pipeline action.
   localparam pipe_ctl_t CTL_FREEZE  = '{pc_en:1'b0, pc_redirect:1'b0, fd_en:1'b0,
                                         fd_flush:1'b0, ex_en:1'b0, ex_bubble:1'b0};
   localparam pipe_ctl_t CTL_BOOT    = '{pc_en:1'b0, pc_redirect:1'b0, fd_en:1'b1,
                                         fd_flush:1'b1, ex_en:1'b1, ex_bubble:1'b1};
   localparam pipe_ctl_t CTL_RUN     = '{pc_en:1'b1, pc_redirect:1'b0, fd_en:1'b1,
                                         fd_flush:1'b0, ex_en:1'b1, ex_bubble:1'b0};
   localparam pipe_ctl_t CTL_LOADUSE = '{pc_en:1'b0, pc_redirect:1'b0, fd_en:1'b0,
                                         fd_flush:1'b0, ex_en:1'b1, ex_bubble:1'b1};
   localparam pipe_ctl_t CTL_REDIR   = '{pc_en:1'b1, pc_redirect:1'b1, fd_en:1'b1,
                                         fd_flush:1'b1, ex_en:1'b1, ex_bubble:1'b1};
   localparam pipe_ctl_t CTL_FLUSH   = '{pc_en:1'b1, pc_redirect:1'b0, fd_en:1'b1,
                                         fd_flush:1'b1, ex_en:1'b1, ex_bubble:1'b1};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: holds at all ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (clear)
         r_count <= '0;
      else if (inc && (r_count != {W{1'b1}}))
         r_count <= r_count + W'(1);
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// FD/EX pipeline sequencing controller: boot warmup, memory freeze, branch
// flush and load-use stall arbitration, plus saturating stall/flush counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int BOOT_CYCLES = 1,
   parameter int BR_PENALTY  = 1,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             should_stall,
   input  logic             br_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             fd_en,
   output logic             fd_flush,
   output logic             ex_en,
   output logic             ex_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             proto_err,
   output logic [1:0]       dbg_state
);

   localparam int PH_W = 16;
   localparam logic [PH_W-1:0] BOOT_LOAD = PH_W'(BOOT_CYCLES - 1);
   localparam logic [PH_W-1:0] BR_LOAD   = PH_W'((BR_PENALTY > 1) ? (BR_PENALTY - 2) : 0);

   pipe_state_t     r_state, w_next_state;
   logic [PH_W-1:0] r_phase, w_next_phase;
   logic            r_proto_err;
   logic            w_proto_set;
   logic            w_run_rules;
   logic            w_stall_inc;
   pipe_ctl_t       w_ctl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= BOOT;
         r_phase     <= BOOT_LOAD;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_phase     <= w_next_phase;
         r_proto_err <= r_proto_err | w_proto_set;
      end
   end

   // Memory handshake: dmem_req rises with the access and must stay high until
   // the cycle dmem_ready is seen; that ready cycle completes the access.
   always_comb begin
      w_ctl        = CTL_FREEZE;
      w_next_state = r_state;
      w_next_phase = r_phase;
      w_proto_set  = 1'b0;
      w_run_rules  = 1'b0;
      case (r_state)
         BOOT: begin
            w_ctl = CTL_BOOT;
            if (r_phase == '0) w_next_state = RUN;
            else               w_next_phase = r_phase - PH_W'(1);
         end
         RUN: begin
            if (dmem_req && !dmem_ready) w_next_state = MEM_WAIT;
            else                         w_run_rules  = 1'b1;
         end
         MEM_WAIT: begin
            if (!dmem_req) begin
               w_proto_set = 1'b1;
               w_run_rules = 1'b1;
            end else if (dmem_ready) begin
               w_run_rules = 1'b1;
            end
         end
         FLUSH: begin
            w_ctl = CTL_FLUSH;
            if (r_phase == '0) w_next_state = RUN;
            else               w_next_phase = r_phase - PH_W'(1);
         end
      endcase

      // Branch beats load-use; the memory term has already been resolved above.
      if (w_run_rules) begin
         if (br_taken) begin
            w_ctl = CTL_REDIR;
            if (BR_PENALTY > 1) begin
               w_next_state = FLUSH;
               w_next_phase = BR_LOAD;
            end else begin
               w_next_state = RUN;
            end
         end else if (should_stall) begin
            w_ctl        = CTL_LOADUSE;
            w_next_state = RUN;
         end else begin
            w_ctl        = CTL_RUN;
            w_next_state = RUN;
         end
      end
   end

   assign w_stall_inc = ((r_state == RUN) || (r_state == MEM_WAIT)) && !w_ctl.pc_en;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_stall_inc),
      .clear (1'b0),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_ctl.pc_redirect),
      .clear (1'b0),
      .count (flush_cnt)
   );

   assign pc_en       = w_ctl.pc_en;
   assign pc_redirect = w_ctl.pc_redirect;
   assign fd_en       = w_ctl.fd_en;
   assign fd_flush    = w_ctl.fd_flush;
   assign ex_en       = w_ctl.ex_en;
   assign ex_bubble   = w_ctl.ex_bubble;
   assign proto_err   = r_proto_err;
   assign dbg_state   = r_state;

endmodule
